// File: rtl/irq_sequencer.sv
// Interrupt/reset sequencer: injects BRK (8'h00) at sync for reset, NMI or unmasked IRQ; stalls core on WAI/STP.
// DB_out/hold are combinational in the sync cycle; nmi_n/irq_n see SYNC_STAGES flops, NMI edge one more.
module irq_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] NMI_VEC     = 8'hFA,
  parameter logic [7:0] RST_VEC     = 8'hFC,
  parameter logic [7:0] IRQ_VEC     = 8'hFE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       wai,
  input  logic       stp,
  input  logic       vec_ack,
  output logic       hold,
  output logic [7:0] vec_lo,
  output logic       b_flag,
  output logic       rdy
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_STOP = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_RST = 2'd0, SRC_NMI = 2'd1, SRC_IRQ = 2'd2, SRC_BRK = 2'd3} src_t;

  state_t state_q, state_d;
  src_t   src_q, src_d;

  logic [SYNC_STAGES-1:0] nmi_sync, irq_sync;
  logic                   nmi_s, irq_s, nmi_s_q;
  logic                   nmi_edge, irq_req, pending;
  logic                   rst_pend, nmi_pend;

  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_edge = nmi_s_q & ~nmi_s;
  assign irq_req  = ~irq_s & ~i_flag;
  assign pending  = rst_pend | nmi_pend | irq_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      nmi_sync <= '1;
      irq_sync <= '1;
      nmi_s_q  <= 1'b1;
    end else begin
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      nmi_s_q  <= nmi_s;
    end
  end

  // A new NMI edge outranks the acknowledge of the previous one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      src_q    <= SRC_RST;
    end else begin
      rst_pend <= rst_pend & ~(vec_ack && src_q == SRC_RST);
      nmi_pend <= nmi_edge | (nmi_pend & ~(vec_ack && src_q == SRC_NMI));
      src_q    <= src_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (stp)      state_d = ST_STOP;
        else if (wai) state_d = ST_WAIT;
      end
      // Wake ignores i_flag; a masked IRQ simply resumes after WAI.
      ST_WAIT: if (nmi_pend || !irq_s) state_d = ST_RUN;
      ST_STOP: state_d = ST_STOP;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    DB_out = DB_in;
    hold   = 1'b0;
    rdy    = (state_q == ST_RUN);
    src_d  = src_q;
    if (!reset) begin
      rdy = 1'b1;
    end else if (state_q != ST_RUN) begin
      hold = 1'b1;
    end else if (sync) begin
      if (pending) begin
        DB_out = 8'h00;
        hold   = 1'b1;
        if (rst_pend)      src_d = SRC_RST;
        else if (nmi_pend) src_d = SRC_NMI;
        else               src_d = SRC_IRQ;
      end else if (DB_in == 8'h00) begin
        src_d = SRC_BRK;
      end
    end
    unique case (src_q)
      SRC_RST: vec_lo = RST_VEC;
      SRC_NMI: vec_lo = NMI_VEC;
      default: vec_lo = IRQ_VEC;
    endcase
    b_flag = (src_q == SRC_BRK);
  end

endmodule
